// File: rtl/led_pattern_pkg.sv
// Shared mode encodings and channel state type for the LED pattern generator.
package led_pattern_pkg;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  typedef enum logic [1:0] {
    S_OFF,
    S_ON,
    S_BLINK,
    S_BURST
  } ch_state_t;

endpackage

// File: rtl/led_channel.sv
// One LED channel: mode FSM with a phase counter for the blink half-period
// and a flash counter that ends a burst after the requested number of flashes.
module led_channel
  import led_pattern_pkg::*;
#(
  parameter int PER_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             we,
  input  logic [1:0]       mode,
  input  logic [PER_W-1:0] half_period,
  input  logic [CNT_W-1:0] burst,
  output logic             led,
  output logic             done
);

  ch_state_t        state_q, state_d;
  logic [PER_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] flash_q, flash_d;
  logic [PER_W-1:0] hp_q, hp_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic             led_q, led_d;
  logic             done_q, done_d;
  logic [PER_W-1:0] last_phase;
  logic [CNT_W-1:0] flash_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      phase_q <= '0;
      flash_q <= '0;
      hp_q    <= '0;
      burst_q <= '0;
      led_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      flash_q <= flash_d;
      hp_q    <= hp_d;
      burst_q <= burst_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

  // A half-period of 0 behaves like 1, so the terminal phase is 0 in both cases.
  // A write takes priority over a coincident tick, which is simply dropped.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    flash_d    = flash_q;
    hp_d       = hp_q;
    burst_d    = burst_q;
    led_d      = led_q;
    done_d     = 1'b0;
    last_phase = (hp_q == '0) ? '0 : hp_q - PER_W'(1);
    flash_next = flash_q + CNT_W'(1);
    if (we) begin
      hp_d    = half_period;
      burst_d = burst;
      phase_d = '0;
      flash_d = '0;
      case (mode)
        MODE_ON: begin
          state_d = S_ON;
          led_d   = 1'b1;
        end
        MODE_BLINK: begin
          state_d = S_BLINK;
          led_d   = 1'b1;
        end
        MODE_BURST: begin
          if (burst == '0) begin
            state_d = S_OFF;
            led_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_BURST;
            led_d   = 1'b1;
          end
        end
        default: begin
          state_d = S_OFF;
          led_d   = 1'b0;
        end
      endcase
    end else if (tick && (state_q == S_BLINK || state_q == S_BURST)) begin
      if (phase_q == last_phase) begin
        phase_d = '0;
        led_d   = ~led_q;
        if (state_q == S_BURST && led_q) begin
          flash_d = flash_next;
          if (flash_next == burst_q) begin
            state_d = S_OFF;
            led_d   = 1'b0;
            done_d  = 1'b1;
          end
        end
      end else begin
        phase_d = phase_q + PER_W'(1);
      end
    end
  end

  always_comb begin
    led  = led_q;
    done = done_q;
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared free-running tick prescaler,
// config write decode and an array of independent led_channel instances.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int CH_W     = 2,
  parameter int TICK_DIV = 2500000,
  parameter int PER_W    = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [1:0]       cfg_mode,
  input  logic [PER_W-1:0] cfg_half_period,
  input  logic [CNT_W-1:0] cfg_burst,
  output logic [N_CH-1:0]  led_out,
  output logic [N_CH-1:0]  ch_done,
  output logic             tick_out
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] presc_q;
  logic [N_CH-1:0]  ch_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else if (presc_q == PRE_LAST) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PRE_W'(1);
    end
  end

  assign tick_out = (presc_q == PRE_LAST);

  // Selects at or beyond N_CH match no channel, so such writes are dropped.
  always_comb begin
    ch_we = '0;
    for (int i = 0; i < N_CH; i++) begin
      ch_we[i] = cfg_we && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    led_channel #(
      .PER_W(PER_W),
      .CNT_W(CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick_out),
      .we         (ch_we[g]),
      .mode       (cfg_mode),
      .half_period(cfg_half_period),
      .burst      (cfg_burst),
      .led        (led_out[g]),
      .done       (ch_done[g])
    );
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with TICK_DIV=4: a write table for static
// modes plus hand-timed sequences for blink, burst, abort and reset corners.
module tb_led_pattern_gen;
  import led_pattern_pkg::*;

  localparam int N_CH     = 4;
  localparam int CH_W     = 2;
  localparam int TICK_DIV = 4;
  localparam int PER_W    = 8;
  localparam int CNT_W    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_we = 1'b0;
  logic             cfg_we3 = 1'b0;
  logic [CH_W-1:0]  cfg_ch = '0;
  logic [1:0]       cfg_mode = '0;
  logic [PER_W-1:0] cfg_half_period = '0;
  logic [CNT_W-1:0] cfg_burst = '0;
  logic [N_CH-1:0]  led_out, ch_done;
  logic             tick_out;
  logic [2:0]       led_out3, ch_done3;
  logic             tick_out3;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [CH_W-1:0] ch;
    logic [1:0]      mode;
    logic [N_CH-1:0] exp_led;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  led_pattern_gen #(
    .N_CH(N_CH), .CH_W(CH_W), .TICK_DIV(TICK_DIV), .PER_W(PER_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_half_period(cfg_half_period), .cfg_burst(cfg_burst),
    .led_out(led_out), .ch_done(ch_done), .tick_out(tick_out)
  );

  // Three-channel build, used to show that an out-of-range select is ignored.
  led_pattern_gen #(
    .N_CH(3), .CH_W(CH_W), .TICK_DIV(TICK_DIV), .PER_W(PER_W), .CNT_W(CNT_W)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we3), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_half_period(cfg_half_period), .cfg_burst(cfg_burst),
    .led_out(led_out3), .ch_done(ch_done3), .tick_out(tick_out3)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [CH_W-1:0] ch, input logic [1:0] mode,
                               input logic [PER_W-1:0] hp, input logic [CNT_W-1:0] b,
                               input bit to3 = 1'b0);
    cfg_ch          = ch;
    cfg_mode        = mode;
    cfg_half_period = hp;
    cfg_burst       = b;
    if (to3) cfg_we3 = 1'b1;
    else     cfg_we  = 1'b1;
    step();
    cfg_we  = 1'b0;
    cfg_we3 = 1'b0;
  endtask

  // Leaves the bench sampling inside a tick cycle so the next write lands on the tick edge.
  task automatic wait_tick();
    bit found = 1'b0;
    for (int i = 0; i < 2 * TICK_DIV; i++) begin
      if (tick_out) begin
        found = 1'b1;
        break;
      end
      step();
    end
    if (!found) checkOutput("tick_timeout", 32'(tick_out), 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{ch: 2'd0, mode: MODE_ON,  exp_led: 4'b0001};
    vecs[1] = '{ch: 2'd3, mode: MODE_ON,  exp_led: 4'b1001};
    vecs[2] = '{ch: 2'd2, mode: MODE_ON,  exp_led: 4'b1101};
    vecs[3] = '{ch: 2'd0, mode: MODE_OFF, exp_led: 4'b1100};
    vecs[4] = '{ch: 2'd3, mode: MODE_OFF, exp_led: 4'b0100};
    vecs[5] = '{ch: 2'd1, mode: MODE_ON,  exp_led: 4'b0110};
    vecs[6] = '{ch: 2'd2, mode: MODE_OFF, exp_led: 4'b0010};
    vecs[7] = '{ch: 2'd1, mode: MODE_OFF, exp_led: 4'b0000};

    #2;
    checkOutput("reset_led", 32'(led_out), 32'd0);
    checkOutput("reset_done", 32'(ch_done), 32'd0);
    checkOutput("reset_tick", 32'(tick_out), 32'd0);
    step();
    step();
    #2 rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      checkOutput("tick_period", 32'(tick_out), 32'((k % 4) == 3));
    end

    $display("[TB] static mode table");
    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].ch, vecs[v].mode, 8'd1, 4'd0);
      checkOutput($sformatf("table_led[%0d]", v), 32'(led_out), 32'(vecs[v].exp_led));
      checkOutput($sformatf("table_done[%0d]", v), 32'(ch_done), 32'd0);
    end

    $display("[TB] blink ch1 half_period=2");
    wait_tick();
    applyStimulus(2'd1, MODE_BLINK, 8'd2, 4'd0);
    for (int j = 0; j < 160; j++) begin
      checkOutput($sformatf("blink_ch1[%0d]", j), 32'(led_out[1]), 32'(((j / 8) % 2) == 0));
      step();
    end

    $display("[TB] burst ch2 half_period=1 burst=3");
    wait_tick();
    applyStimulus(2'd2, MODE_BURST, 8'd1, 4'd3);
    for (int j = 0; j < 32; j++) begin
      checkOutput($sformatf("burst_led[%0d]", j), 32'(led_out[2]), 32'((j < 20) && ((j / 4) % 2 == 0)));
      checkOutput($sformatf("burst_done[%0d]", j), 32'(ch_done[2]), 32'(j == 20));
      step();
    end

    $display("[TB] burst=0 and half_period=0");
    applyStimulus(2'd3, MODE_BURST, 8'd5, 4'd0);
    checkOutput("burst0_led", 32'(led_out[3]), 32'd0);
    checkOutput("burst0_done", 32'(ch_done[3]), 32'd1);
    step();
    checkOutput("burst0_done_clear", 32'(ch_done[3]), 32'd0);
    checkOutput("burst0_led_hold", 32'(led_out[3]), 32'd0);
    wait_tick();
    applyStimulus(2'd0, MODE_BLINK, 8'd0, 4'd0);
    for (int j = 0; j < 16; j++) begin
      checkOutput($sformatf("hp0_ch0[%0d]", j), 32'(led_out[0]), 32'(((j / 4) % 2) == 0));
      step();
    end

    $display("[TB] write OFF on tick, out-of-range select");
    wait_tick();
    applyStimulus(2'd1, MODE_OFF, 8'd2, 4'd0);
    for (int j = 0; j < 12; j++) begin
      checkOutput($sformatf("off_on_tick[%0d]", j), 32'(led_out[1]), 32'd0);
      step();
    end
    applyStimulus(2'd0, MODE_ON, 8'd1, 4'd0, 1'b1);
    checkOutput("n3_ch0_on", 32'(led_out3), 32'b001);
    applyStimulus(2'd3, MODE_ON, 8'd1, 4'd0, 1'b1);
    checkOutput("n3_ch3_ignored", 32'(led_out3), 32'b001);
    checkOutput("n3_ch3_done", 32'(ch_done3), 32'd0);
    step();
    checkOutput("n3_ch3_later", 32'(led_out3), 32'b001);
    applyStimulus(2'd2, MODE_ON, 8'd1, 4'd0, 1'b1);
    checkOutput("n3_ch2_on", 32'(led_out3), 32'b101);

    $display("[TB] async reset mid-burst");
    wait_tick();
    applyStimulus(2'd2, MODE_BURST, 8'd2, 4'd5);
    for (int j = 0; j < 5; j++) step();
    checkOutput("preburst_led", 32'(led_out[2]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_led", 32'(led_out), 32'd0);
    checkOutput("async_done", 32'(ch_done), 32'd0);
    checkOutput("async_tick", 32'(tick_out), 32'd0);
    checkOutput("async_led3", 32'(led_out3), 32'd0);
    step();
    step();
    #2 rst_n = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step();
      checkOutput($sformatf("post_tick[%0d]", k), 32'(tick_out), 32'((k % 4) == 3));
      checkOutput($sformatf("post_led[%0d]", k), 32'(led_out), 32'd0);
      checkOutput($sformatf("post_done[%0d]", k), 32'(ch_done), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Multi-channel LED pattern generator and parametrised successor to the single free-running flasher. It has one shared tick prescaler and N_CH independent channels. Each channel can be set through a simple write port to one of four modes: OFF, ON, BLINK (continuous), or BURST (N flashes, then stop). It sits between board LEDs and a control FSM or switch decoder, and reports burst completion back to that controller.

Parameters:
N_CH, 4, number of LED channels
CH_W, 2, width of channel select; must satisfy 2**CH_W >= N_CH
TICK_DIV, 2500000, clk cycles per timebase tick (minimum 2)
PER_W, 8, width of half-period field, in ticks
CNT_W, 4, width of burst flash count

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
cfg_we  in  1  config write strobe, one cycle
cfg_ch  in  CH_W  target channel
cfg_mode  in  2  0=OFF 1=ON 2=BLINK 3=BURST
cfg_half_period  in  PER_W  LED on-time and off-time, in ticks
cfg_burst  in  CNT_W  flash count for BURST mode
led_out  out  N_CH  LED drive, registered, 1 = lit
ch_done  out  N_CH  one-cycle pulse when a channel's BURST completes
tick_out  out  1  one-cycle timebase tick, for debug and sync

Behaviour:
- Reset: clk and a single asynchronous, active-low reset (rst_n). On rst_n low, all of the following clear immediately, regardless of clk:
  - prescaler = 0
  - led_out = 0, ch_done = 0, tick_out = 0
  - every channel goes to OFF with its counters at 0
  - Release is synchronous to the next clk edge.
- Prescaler: counts 0..TICK_DIV-1, then wraps to 0. tick_out is high for exactly the cycle in which the count equals TICK_DIV-1. Tick period is exactly TICK_DIV cycles.
- Config write:
  - When cfg_we=1 and cfg_ch < N_CH, the selected channel latches mode, half_period and burst at the clock edge.
  - cfg_ch >= N_CH: the write is ignored, with no side effects.
  - Effect is visible on led_out in the cycle after the write edge (1-cycle latency).
  - A write resets that channel's phase counter and flash counter to 0 and restarts its pattern. Other channels are untouched.
- Half-period: a value of 0 is treated as 1.
- Channel FSM states: S_OFF, S_ON, S_BLINK, S_BURST.
  - S_OFF: led=0; no state change without a write.
  - S_ON: led=1; no state change without a write.
  - S_BLINK:
    - Entry sets led=1 and phase=0.
    - On each tick, phase increments. When phase reaches half_period-1 on a tick, led toggles and phase returns to 0.
    - Runs indefinitely.
  - S_BURST:
    - Entry behaves like BLINK entry, but with burst=0 the channel goes straight to S_OFF with led=0 and ch_done pulsed in the cycle after the write.
    - Otherwise it blinks, incrementing the flash counter on each on-to-off transition.
    - When the counter reaches burst, it moves to S_OFF with led=0 and pulses ch_done for one cycle on the same edge.
- Simultaneous write and tick on the same channel: the write wins. That tick is discarded for that channel only.
- A write during an active BURST aborts it. No ch_done pulse is generated for the aborted burst.
- The prescaler is free-running and never reset by writes, so the first toggle after a write occurs within half_period ticks minus up to TICK_DIV-1 cycles.
- Arithmetic: all counters are unsigned. The phase counter is PER_W bits wide and the flash counter CNT_W bits wide. Neither can overflow, because the compare bounds them.

Decomposition:
- Package led_pattern_pkg holds:
  - the mode encoding constants MODE_OFF/ON/BLINK/BURST
  - the channel state typedef
- Sub-module led_channel contains one channel's FSM, phase counter and flash counter. Its inputs are tick, a write strobe, and the config fields; its outputs are led and done.
- The top level contains:
  - the prescaler
  - cfg_ch decode into per-channel write strobes
  - a generate loop of N_CH led_channel instances

Test Plan (TICK_DIV=4, N_CH=4):
1. Reset, then write ch0 ON -> led_out=0001 one cycle after the write; ch1-3 stay 0; tick_out pulses every 4 cycles.
2. Write ch1 BLINK, half_period=2 -> led_out[1]=1 immediately, then toggles every 2 ticks (8 cycles) steadily for 10 periods.
3. Write ch2 BURST, half_period=1, burst=3 -> exactly 3 on-pulses of 4 cycles each; after the 3rd off edge led_out[2]=0 and ch_done[2] pulses exactly 1 cycle; led_out[2] stays 0 thereafter.
4. BURST with burst=0 -> led stays 0 and ch_done pulses in the cycle after the write. Half_period=0 in BLINK -> behaves like half_period=1.
5. Write ch1 OFF in the same cycle as tick_out=1 while it is blinking -> led_out[1]=0 next cycle with no extra toggle. Write with cfg_ch=3 while N_CH=3 build -> no output change.
6. Assert rst_n=0 mid-burst, between clk edges -> led_out and ch_done go to 0 immediately with no pending done after release; the prescaler restarts from 0.
